// File: rtl/mix_round_engine_pkg.sv
// Shared types and constants for the mix round engine: FSM states, stage codes,
// and the per-lane multiply/add constants used by the MUL_ADD stage.
package mix_round_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6} stage_e;

   localparam int unsigned NUM_STAGES = 7;

   localparam int unsigned MULT [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
   localparam int unsigned ADDC [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

endpackage

// File: rtl/mix_round_engine_if.sv
// Job interface of the mix round engine: seed/mask/start in, busy/done/result out.
// With MIX_CHECKSUM_EN defined the interface also carries the registered lane checksum.
interface mix_round_engine_if
   import mix_round_pkg::*;
#(
   parameter int unsigned LANES = 8,
   parameter int unsigned WIDTH = 32
);

   logic                    start;
   logic [NUM_STAGES-1:0]   stage_mask;
   logic [LANES*WIDTH-1:0]  seed;
   logic                    busy;
   logic                    done;
   logic [LANES*WIDTH-1:0]  result;
`ifdef MIX_CHECKSUM_EN
   logic [WIDTH-1:0]        checksum;

   modport master (output start, stage_mask, seed, input busy, done, result, checksum);
   modport slave  (input start, stage_mask, seed, output busy, done, result, checksum);
`else
   modport master (output start, stage_mask, seed, input busy, done, result);
   modport slave  (input start, stage_mask, seed, output busy, done, result);
`endif

endinterface

// File: rtl/mix_round_engine_sweep.sv
// Combinational single-stage sweep over all lanes. Lanes update in index order,
// so lane i already sees the new values of lanes below it within the same sweep.
module mix_stage_sweep
   import mix_round_pkg::*;
#(
   parameter int unsigned LANES = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic [LANES*WIDTH-1:0] lanes_in,
   input  stage_e                 stage,
   output logic [LANES*WIDTH-1:0] lanes_out
);

   localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

   logic [WIDTH-1:0] o [LANES];

   function automatic logic [IW-1:0] ix(input int unsigned i, input int unsigned k);
      return IW'((i + k) % LANES);
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) o[ix(i, 0)] = lanes_in[i*WIDTH +: WIDTH];
      // o is updated in place so later lanes read already-swept neighbours
      for (int unsigned i = 0; i < LANES; i++) begin
         case (stage)
            S0: o[ix(i, 0)] = o[ix(i, 0)] + WIDTH'(i);
            S1: o[ix(i, 0)] = o[ix(i, 0)] + o[ix(i, LANES-1)];
            S2: o[ix(i, 0)] = o[ix(i, 0)] + o[ix(i, 1)] - o[ix(i, LANES-3)];
            S3: o[ix(i, 0)] = o[ix(i, 0)] ^ (o[ix(i, 3)] << (WIDTH/2));
            S4: o[ix(i, 0)] = o[ix(i, 0)] - (o[ix(i, 2)] >> (WIDTH/2 + 1))
                              + (o[ix(i, 4)] >> (3*WIDTH/8));
            S5: o[ix(i, 0)] = o[ix(i, 0)] + o[ix(i, LANES-1)] - o[ix(i, LANES-2)];
            S6: o[ix(i, 0)] = o[ix(i, 0)] * WIDTH'(MULT[i[2:0]]) + WIDTH'(ADDC[i[2:0]]);
            default: ;
         endcase
      end
      lanes_out = '0;
      for (int unsigned i = 0; i < LANES; i++) lanes_out[i*WIDTH +: WIDTH] = o[ix(i, 0)];
   end

endmodule

// File: rtl/mix_round_engine.sv
// Mix round engine top: job FSM, stage/round counters and lane registers.
// Optional checksum output is enabled by defining MIX_CHECKSUM_EN.
module mix_round_engine
   import mix_round_pkg::*;
#(
   parameter int unsigned LANES  = 8,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ROUNDS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   mix_round_engine_if.slave  bus
);

   localparam int unsigned        RW         = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [RW-1:0]      LAST_ROUND = RW'(ROUNDS - 1);

   state_e                  state_q, state_d;
   stage_e                  stage_q, stage_d;
   logic [RW-1:0]           round_q, round_d;
   logic [NUM_STAGES-1:0]   mask_q, mask_d;
   logic [LANES*WIDTH-1:0]  lanes_q, lanes_d;
   logic [LANES*WIDTH-1:0]  sweep_out;
`ifdef MIX_CHECKSUM_EN
   logic [WIDTH-1:0]        checksum_q, checksum_d;
`endif

   mix_stage_sweep #(.LANES(LANES), .WIDTH(WIDTH)) u_sweep (
      .lanes_in  (lanes_q),
      .stage     (stage_q),
      .lanes_out (sweep_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         stage_q    <= S0;
         round_q    <= '0;
         mask_q     <= '0;
         lanes_q    <= '0;
`ifdef MIX_CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         stage_q    <= stage_d;
         round_q    <= round_d;
         mask_q     <= mask_d;
         lanes_q    <= lanes_d;
`ifdef MIX_CHECKSUM_EN
         checksum_q <= checksum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      round_d = round_q;
      mask_d  = mask_q;
      lanes_d = lanes_q;
`ifdef MIX_CHECKSUM_EN
      checksum_d = checksum_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               lanes_d = bus.seed;
               mask_d  = bus.stage_mask;
               stage_d = S0;
               round_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // a masked-off stage still spends its cycles, keeping latency fixed
            lanes_d = mask_q[stage_q] ? sweep_out : lanes_q;
            if (round_q == LAST_ROUND) begin
               round_d = '0;
               if (stage_q == S6) begin
                  state_d = DONE;
`ifdef MIX_CHECKSUM_EN
                  checksum_d = '0;
                  for (int unsigned i = 0; i < LANES; i++)
                     checksum_d = checksum_d ^ lanes_d[i*WIDTH +: WIDTH];
`endif
               end else begin
                  stage_d = stage_e'(stage_q + 3'd1);
               end
            end else begin
               round_d = round_q + RW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy   = (state_q == RUN);
   assign bus.done   = (state_q == DONE);
   assign bus.result = lanes_q;
`ifdef MIX_CHECKSUM_EN
   assign bus.checksum = checksum_q;
`endif

endmodule
